p4_router_ing_arbiter: RTL
==========================

Name: p4_router_ing_arbiter

Overview:
Packet-granular weighted round-robin arbiter that converges NUM_PORTS equal-width AXIS ingress channels onto the single converged ingress bus ahead of the VNP4 wrapper. It generalises the fixed round-robin merge with several additions:
- per-port weights (consecutive-packet bursts);
- per-port enable;
- tagging of the ingress port index into tuser;
- a maximum-packet-length guard that truncates runaway packets.

It sits between the per-width ingress buffers and the converged bus in p4_router_ingress.

Parameters:
NUM_PORTS, 4, number of ingress channels (1..32)
DATA_BYTES, 8, tdata width in bytes on all channels and the output
PORT_ID_WIDTH, 5, width of the port index field in out_axis.tuser; must be >= clog2(NUM_PORTS)
WEIGHT_WIDTH, 4, width of each per-port weight
MAX_PKT_BEATS, 1200, beats after which a packet is forcibly terminated (MTU 9600 / 8 B)

Ports:
clk_ifc  input  Clock_int  core clock; single clock domain
sreset_ifc  input  Reset_int  reset, synchronous, active-high
in_axis[NUM_PORTS]  input  AXIS_int.Slave DATA_BYTES  ingress channels (tdata, tkeep, tvalid, tready, tlast)
out_axis  output  AXIS_int.Master DATA_BYTES  converged bus; tuser[PORT_ID_WIDTH-1:0] = source port index
port_weight  input  NUM_PORTS*WEIGHT_WIDTH  packets granted per turn; 0 = port disabled
trunc_event  output  NUM_PORTS  one-cycle pulse per port when a packet is truncated
active_port  output  PORT_ID_WIDTH  index of the currently granted port
busy  output  1  high while a packet is in flight

Behaviour:
Reset (sreset_ifc, synchronous, active-high):
- out_axis.tvalid=0, all in_axis.tready=0, trunc_event=0, active_port=0, busy=0.
- Round-robin pointer=0; credit=0; beat counter=0; FSM=IDLE.
- Reset mid-packet abandons the packet immediately with no partial tlast generated. Downstream shares the same reset.

FSM states: IDLE, PASS, DRAIN.

IDLE:
- Search ports starting at pointer, wrapping modulo NUM_PORTS.
- Grant the first port that has tvalid=1 and port_weight != 0.
- On grant: load credit=weight, set active_port, go to PASS.
- The grant decision takes 1 cycle. No grant when every valid port has weight 0.

PASS:
- in_axis[g].tready = !out_axis.tvalid || out_axis.tready. All other tready=0.
- Output is a registered slice: 1-cycle latency and full throughput (1 beat/cycle when the sink is always ready).
- tdata, tkeep and tlast pass through unchanged; tuser = g zero-extended.
- Beat counter increments on each accepted beat.
- On accepted input tlast:
  - credit decrements and the beat counter clears.
  - If credit reaches 0, or in_axis[g].tvalid=0 on the following cycle, pointer = g+1 (mod NUM_PORTS) and go to IDLE.
  - Otherwise stay in PASS on the same port for the next packet. The 0-cycle gap applies only if the next beat is already valid.
- Truncation: on the accepted beat with counter = MAX_PKT_BEATS-1 and no tlast:
  - Emit that beat with tlast forced to 1.
  - Pulse trunc_event[g] and go to DRAIN.

DRAIN:
- in_axis[g].tready=1 unconditionally and nothing is forwarded.
- On accepted tlast: pointer advances and go to IDLE.
- A truncated packet consumes one credit.

Handshake and weight rules:
- AXIS rules: tvalid, once asserted, is held with stable data until tready. Backpressure on out_axis stalls only the granted port.
- A weight change applies at the next grant. A weight changed to 0 mid-packet does not abort the current packet.
- busy=1 in PASS and DRAIN; active_port holds its last value in IDLE.

Boundary conditions:
- NUM_PORTS=1: the pointer stays 0.
- Single-beat packets (tlast on the first beat) are legal.
- A packet of exactly MAX_PKT_BEATS beats with tlast on the last beat is not truncated.

Optional Feature:
Macro P4_ROUTER_ING_ARB_STATS_EN.
- When defined: adds output pkt_count[NUM_PORTS][32] and input stats_clear.
  - pkt_count counts forwarded packets per port (truncated packets included).
  - The counters saturate at 0xFFFFFFFF and reset to 0.
  - stats_clear zeroes all counters in the next cycle and takes priority over a simultaneous increment.
- When undefined: no counters or ports exist, and all other behaviour is identical.

Test Plan:
1. Equal weights: 4 ports, weights 1, each port has three 4-beat packets queued, sink always ready -> output port order 0,1,2,3,0,1,2,3,..., tuser matches the source, 48 beats in 48+grant cycles, no truncation.
2. Weights {3,1,0,2}, all ports backlogged -> per round: 3 packets from port 0, 1 from port 1, none from port 2, 2 from port 3; repeats; port 2 tready never asserted.
3. Truncation with MAX_PKT_BEATS=16: port 1 sends a 20-beat packet -> output beat 16 carries tlast=1; trunc_event[1] pulses once; input beats 17-20 are consumed and dropped; the next packet from port 2 is intact.
4. Backpressure: out_axis.tready toggles 1,0,1,0 during a 10-beat packet -> no beat lost or duplicated, data matches in order, other ports' tready stays 0.
5. Reset mid-packet: assert reset at beat 5 of 10 -> the next cycle has out tvalid=0, all tready=0, pointer=0; after release a fresh packet from port 0 forwards correctly.
6. (STATS_EN) Port 0 sends 3 packets, then stats_clear coincides with a 4th tlast -> pkt_count[0] reads 3 and then 0; the later count is correct.

Source files
------------

// File: rtl/p4_router_ing_arbiter.sv
// ---------------------------------------------------------------------------
// p4_router_ing_arbiter
//
// Packet-granular weighted round-robin arbiter. It merges NUM_PORTS equal-width
// AXI-Stream ingress channels onto the single converged ingress bus that feeds
// the VNP4 wrapper.
//
// Features:
//   - per-port weight: number of back-to-back packets granted per turn
//     (weight 0 disables the port)
//   - source port index tagged into out_axis_tuser
//   - runaway packets are cut at MAX_PKT_BEATS beats: the cut beat carries a
//     forced tlast and the rest of the packet is drained and dropped
//
// Optional build macro: P4_ROUTER_ING_ARB_STATS_EN
//   When defined, the block adds per-port saturating forwarded-packet counters
//   (pkt_count) and a synchronous clear input (stats_clear).
//
// Ports:
//   clk_ifc          core clock (single clock domain)
//   sreset_ifc       synchronous active-high reset
//   in_axis_*        NUM_PORTS ingress channels (tdata/tkeep/tvalid/tready/tlast)
//   out_axis_*       converged egress bus (registered), tuser = source port
//   port_weight      per-port packets per turn, 0 = disabled
//   trunc_event      one-cycle pulse on the port whose packet was truncated
//   active_port      index of the currently / most recently granted port
//   busy             high while a packet is in flight (PASS or DRAIN)
//   stats_clear      (stats build only) zero all packet counters
//   pkt_count        (stats build only) forwarded packets per port
// ---------------------------------------------------------------------------
module p4_router_ing_arbiter #(
  parameter int NUM_PORTS     = 4,
  parameter int DATA_BYTES    = 8,
  parameter int PORT_ID_WIDTH = 5,
  parameter int WEIGHT_WIDTH  = 4,
  parameter int MAX_PKT_BEATS = 1200
) (
  input  logic                                     clk_ifc,
  input  logic                                     sreset_ifc,
  input  logic [NUM_PORTS-1:0][DATA_BYTES*8-1:0]   in_axis_tdata,
  input  logic [NUM_PORTS-1:0][DATA_BYTES-1:0]     in_axis_tkeep,
  input  logic [NUM_PORTS-1:0]                     in_axis_tvalid,
  output logic [NUM_PORTS-1:0]                     in_axis_tready,
  input  logic [NUM_PORTS-1:0]                     in_axis_tlast,
  output logic [DATA_BYTES*8-1:0]                  out_axis_tdata,
  output logic [DATA_BYTES-1:0]                    out_axis_tkeep,
  output logic                                     out_axis_tvalid,
  input  logic                                     out_axis_tready,
  output logic                                     out_axis_tlast,
  output logic [PORT_ID_WIDTH-1:0]                 out_axis_tuser,
  input  logic [NUM_PORTS-1:0][WEIGHT_WIDTH-1:0]   port_weight,
  output logic [NUM_PORTS-1:0]                     trunc_event,
  output logic [PORT_ID_WIDTH-1:0]                 active_port,
  output logic                                     busy
`ifdef P4_ROUTER_ING_ARB_STATS_EN
  ,
  input  logic                                     stats_clear,
  output logic [NUM_PORTS-1:0][31:0]               pkt_count
`endif
);

  localparam int CNT_W = $clog2(MAX_PKT_BEATS + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PASS  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]               state_q;
  logic [PORT_ID_WIDTH-1:0] ptr_q;
  logic [WEIGHT_WIDTH-1:0]  credit_q;
  logic [CNT_W-1:0]         beat_cnt_q;
  // Set for exactly one cycle after a non-final packet of a burst completes;
  // during that cycle an idle source ends its turn early.
  logic                     boundary_q;

  // -------------------------------------------------------------------------
  // Grant search: rotate the eligibility vector so the pointer lands at bit 0,
  // take the lowest set bit, then map the offset back to a port index.
  // -------------------------------------------------------------------------
  logic [NUM_PORTS-1:0]     elig;
  logic [2*NUM_PORTS-1:0]   elig_dbl;
  logic [NUM_PORTS-1:0]     elig_rot;
  logic                     found;
  logic [PORT_ID_WIDTH:0]   grant_sum;
  logic [PORT_ID_WIDTH-1:0] grant_idx;
  logic [WEIGHT_WIDTH-1:0]  grant_weight;

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      elig[p] = in_axis_tvalid[p] && (port_weight[p] != '0);
    end
  end

  assign elig_dbl = {elig, elig};
  assign elig_rot = NUM_PORTS'(elig_dbl >> ptr_q);

  always_comb begin
    found     = 1'b0;
    grant_sum = '0;
    grant_idx = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!found && elig_rot[i]) begin
        found     = 1'b1;
        grant_sum = {1'b0, ptr_q} + (PORT_ID_WIDTH + 1)'(i);
        if (grant_sum >= (PORT_ID_WIDTH + 1)'(NUM_PORTS)) begin
          grant_sum = grant_sum - (PORT_ID_WIDTH + 1)'(NUM_PORTS);
        end
        grant_idx = grant_sum[PORT_ID_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    grant_weight = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (grant_idx == PORT_ID_WIDTH'(p)) begin
        grant_weight = port_weight[p];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Selection of the granted channel. A one-hot decode of active_port keeps
  // every index a compile-time constant.
  // -------------------------------------------------------------------------
  logic [NUM_PORTS-1:0]    sel_onehot;
  logic [DATA_BYTES*8-1:0] sel_tdata;
  logic [DATA_BYTES-1:0]   sel_tkeep;
  logic                    sel_tvalid;
  logic                    sel_tlast;

  always_comb begin
    sel_onehot = '0;
    sel_tdata  = '0;
    sel_tkeep  = '0;
    sel_tvalid = 1'b0;
    sel_tlast  = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (active_port == PORT_ID_WIDTH'(p)) begin
        sel_onehot[p] = 1'b1;
        sel_tdata     = in_axis_tdata[p];
        sel_tkeep     = in_axis_tkeep[p];
        sel_tvalid    = in_axis_tvalid[p];
        sel_tlast     = in_axis_tlast[p];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Handshake terms
  // -------------------------------------------------------------------------
  logic                     pass_ready;
  logic                     pass_accept;
  logic                     drain_accept;
  logic                     at_limit;
  logic                     trunc_now;
  logic                     last_credit;
  logic [PORT_ID_WIDTH-1:0] next_ptr;

  // The output register can take a new beat when empty or being emptied.
  assign pass_ready   = !out_axis_tvalid || out_axis_tready;
  assign pass_accept  = (state_q == PASS) && sel_tvalid && pass_ready;
  assign drain_accept = (state_q == DRAIN) && sel_tvalid;
  assign at_limit     = (beat_cnt_q == CNT_W'(MAX_PKT_BEATS - 1));
  assign trunc_now    = pass_accept && at_limit && !sel_tlast;
  assign last_credit  = (credit_q <= WEIGHT_WIDTH'(1));
  assign next_ptr     = (active_port == PORT_ID_WIDTH'(NUM_PORTS - 1)) ?
                        '0 : active_port + PORT_ID_WIDTH'(1);

  // Only the granted port ever sees tready; reset forces everything low so
  // no beat is consumed during the reset cycle.
  always_comb begin
    in_axis_tready = '0;
    if (!sreset_ifc) begin
      if (state_q == PASS) begin
        in_axis_tready = pass_ready ? sel_onehot : '0;
      end else if (state_q == DRAIN) begin
        in_axis_tready = sel_onehot;
      end
    end
  end

  assign busy = (state_q != IDLE);

  // -------------------------------------------------------------------------
  // Arbitration FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_ifc) begin
    if (sreset_ifc) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      credit_q    <= '0;
      beat_cnt_q  <= '0;
      boundary_q  <= 1'b0;
      active_port <= '0;
      trunc_event <= '0;
    end else begin
      trunc_event <= trunc_now ? sel_onehot : '0;
      boundary_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (found) begin
            active_port <= grant_idx;
            credit_q    <= grant_weight;
            beat_cnt_q  <= '0;
            state_q     <= PASS;
          end
        end
        PASS: begin
          if (pass_accept) begin
            if (trunc_now) begin
              // The truncated packet still uses up one credit, but the turn
              // always ends after draining its tail.
              beat_cnt_q <= '0;
              credit_q   <= credit_q - WEIGHT_WIDTH'(1);
              state_q    <= DRAIN;
            end else if (sel_tlast) begin
              beat_cnt_q <= '0;
              credit_q   <= credit_q - WEIGHT_WIDTH'(1);
              if (last_credit) begin
                ptr_q   <= next_ptr;
                state_q <= IDLE;
              end else begin
                boundary_q <= 1'b1;
              end
            end else begin
              beat_cnt_q <= beat_cnt_q + CNT_W'(1);
            end
          end else if (boundary_q && !sel_tvalid) begin
            // Credit remains but the source has nothing ready right now:
            // give up the turn instead of holding the bus.
            ptr_q   <= next_ptr;
            state_q <= IDLE;
          end
        end
        DRAIN: begin
          if (drain_accept && sel_tlast) begin
            ptr_q   <= next_ptr;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Registered output slice. A beat is loaded whenever the granted input is
  // accepted; otherwise a consumed beat empties the register.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_ifc) begin
    if (sreset_ifc) begin
      out_axis_tvalid <= 1'b0;
      out_axis_tdata  <= '0;
      out_axis_tkeep  <= '0;
      out_axis_tlast  <= 1'b0;
      out_axis_tuser  <= '0;
    end else if (pass_accept) begin
      out_axis_tvalid <= 1'b1;
      out_axis_tdata  <= sel_tdata;
      out_axis_tkeep  <= sel_tkeep;
      out_axis_tlast  <= sel_tlast || at_limit;
      out_axis_tuser  <= active_port;
    end else if (out_axis_tready) begin
      out_axis_tvalid <= 1'b0;
    end
  end

`ifdef P4_ROUTER_ING_ARB_STATS_EN
  // -------------------------------------------------------------------------
  // Per-port forwarded packet counters. A packet counts when its final
  // forwarded beat (real or forced tlast) is accepted. Clear wins over a
  // simultaneous increment; counters stick at all-ones.
  // -------------------------------------------------------------------------
  logic pkt_end;

  assign pkt_end = pass_accept && (sel_tlast || at_limit);

  always_ff @(posedge clk_ifc) begin
    if (sreset_ifc) begin
      pkt_count <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (stats_clear) begin
          pkt_count[p] <= '0;
        end else if (pkt_end && sel_onehot[p] && (pkt_count[p] != 32'hFFFF_FFFF)) begin
          pkt_count[p] <= pkt_count[p] + 32'd1;
        end
      end
    end
  end
`endif

endmodule
